// File: rtl/regex_cpu_windowed.sv
// regex_cpu_windowed: single-thread regex VM core working on a window of CC_WINDOW characters
module regex_cpu_windowed #(
  parameter int PC_WIDTH          = 8,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int CC_ID_BITS        = 2,
  parameter int OPCODE_WIDTH      = 3,
  parameter int DATA_WIDTH        = 13,
  parameter int MEMORY_ADDR_WIDTH = 11,
  localparam int CC_WINDOW        = 2 ** CC_ID_BITS,
  localparam int INSTR_W          = OPCODE_WIDTH + DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CC_WINDOW*CHARACTER_WIDTH-1:0] window_chars,
  input  logic                                 input_pc_valid,
  input  logic [PC_WIDTH-1:0]                  input_pc,
  input  logic [CC_ID_BITS-1:0]                input_cc_id,
  output logic                                 input_pc_ready,
  output logic                                 memory_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]         memory_addr,
  input  logic                                 memory_ready,
  input  logic                                 memory_data_valid,
  input  logic [INSTR_W-1:0]                   memory_data,
  output logic                                 output_pc_valid,
  output logic [PC_WIDTH-1:0]                  output_pc,
  output logic [CC_ID_BITS-1:0]                output_cc_id,
  input  logic                                 output_pc_ready,
  output logic                                 accepts,
  output logic                                 busy
);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACCEPT         = 0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SPLIT          = 1;
  localparam logic [OPCODE_WIDTH-1:0] OP_MATCH          = 2;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP            = 3;
  localparam logic [OPCODE_WIDTH-1:0] OP_END            = 4;
  localparam logic [OPCODE_WIDTH-1:0] OP_MATCH_ANY      = 5;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT_MATCH      = 6;
  localparam logic [OPCODE_WIDTH-1:0] OP_ACCEPT_PARTIAL = 7;

  typedef enum logic [2:0] {S_IDLE, S_FETCH_SEND, S_FETCH_WAIT, S_EXEC_1, S_EXEC_2} state_t;

  state_t                     state, state_n;
  logic [PC_WIDTH-1:0]        pc, pc_inc, d_pc, emit_pc;
  logic [CC_ID_BITS-1:0]      cc_id, cc_inc, emit_cc;
  logic [INSTR_W-1:0]         instr;
  logic [OPCODE_WIDTH-1:0]    opcode;
  logic [DATA_WIDTH-1:0]      d;
  logic [CHARACTER_WIDTH-1:0] c, d_char;
  logic                       emit, done, take;

  assign opcode = instr[INSTR_W-1 -: OPCODE_WIDTH];
  assign d      = instr[DATA_WIDTH-1:0];
  assign d_pc   = d[PC_WIDTH-1:0];
  assign d_char = d[CHARACTER_WIDTH-1:0];
  assign c      = window_chars[cc_id*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  assign pc_inc = pc + 1'b1;
  assign cc_inc = cc_id + 1'b1;

  always_comb begin
    state_n      = state;
    memory_valid = 1'b0;
    emit         = 1'b0;
    emit_pc      = pc_inc;
    emit_cc      = cc_id;
    accepts      = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE:       state_n = input_pc_valid ? S_FETCH_SEND : S_IDLE;
      S_FETCH_SEND: begin
        memory_valid = 1'b1;
        state_n      = memory_ready ? S_FETCH_WAIT : S_FETCH_SEND;
      end
      S_FETCH_WAIT: state_n = memory_data_valid ? S_EXEC_1 : S_FETCH_WAIT;
      S_EXEC_1: begin
        accepts = (opcode == OP_ACCEPT && c == '0) || opcode == OP_ACCEPT_PARTIAL;
        emit    = opcode == OP_SPLIT || opcode == OP_JMP ||
                  (opcode == OP_MATCH && c == d_char) ||
                  (opcode == OP_MATCH_ANY && c != '0) ||
                  (opcode == OP_NOT_MATCH && DATA_WIDTH'(c) != d && c != '0);
        emit_pc = opcode == OP_JMP ? d_pc : pc_inc;
        emit_cc = (opcode == OP_SPLIT || opcode == OP_JMP) ? cc_id : cc_inc;
        if (opcode == OP_SPLIT)
          state_n = output_pc_ready ? S_EXEC_2 : S_EXEC_1;
        else
          done = !emit || output_pc_ready;
      end
      S_EXEC_2: begin
        emit    = 1'b1;
        emit_pc = d_pc;
        done    = output_pc_ready;
      end
      default:      state_n = S_IDLE;
    endcase
    // a finishing thread may hand over directly to the next waiting one
    if (done) state_n = input_pc_valid ? S_FETCH_SEND : S_IDLE;
  end

  assign input_pc_ready  = state == S_IDLE || done;
  assign take            = input_pc_ready && input_pc_valid;
  assign memory_addr     = MEMORY_ADDR_WIDTH'(pc);
  assign output_pc_valid = emit;
  assign output_pc       = emit ? emit_pc : '0;
  assign output_cc_id    = emit ? emit_cc : '0;
  assign busy            = state != S_IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      cc_id <= '0;
      instr <= {OP_END, {DATA_WIDTH{1'b0}}};
    end else begin
      state <= state_n;
      if (take) begin
        pc    <= input_pc;
        cc_id <= input_cc_id;
      end
      if (state == S_FETCH_WAIT && memory_data_valid) instr <= memory_data;
    end
  end
endmodule

// File: tb/tb_regex_cpu_windowed.sv
// tb_regex_cpu_windowed: directed self-checking bench for regex_cpu_windowed
module tb_regex_cpu_windowed;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] window_chars;
  logic        input_pc_valid = 1'b0;
  logic [7:0]  input_pc = '0;
  logic [1:0]  input_cc_id = '0;
  logic        input_pc_ready;
  logic        memory_valid;
  logic [10:0] memory_addr;
  logic        memory_ready = 1'b0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        output_pc_valid;
  logic [7:0]  output_pc;
  logic [1:0]  output_cc_id;
  logic        output_pc_ready = 1'b1;
  logic        accepts;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  int          hs = 0;
  int          acc = 0;
  int          hs0, acc0;

  regex_cpu_windowed dut (
    .clk(clk), .reset(reset), .window_chars(window_chars),
    .input_pc_valid(input_pc_valid), .input_pc(input_pc), .input_cc_id(input_cc_id),
    .input_pc_ready(input_pc_ready), .memory_valid(memory_valid), .memory_addr(memory_addr),
    .memory_ready(memory_ready), .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .output_pc_valid(output_pc_valid), .output_pc(output_pc), .output_cc_id(output_cc_id),
    .output_pc_ready(output_pc_ready), .accepts(accepts), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (output_pc_valid && output_pc_ready) hs++;
    if (accepts) acc++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [12:0] d);
    return {op, d};
  endfunction

  // offers a thread in idle, then serves its fetch; returns at the negedge inside S_EXEC_1
  task automatic run(input logic [7:0] pc, input logic [1:0] cc, input logic [15:0] ins, input int lat);
    input_pc_valid = 1'b1;
    input_pc       = pc;
    input_cc_id    = cc;
    tick();
    input_pc_valid = 1'b0;
    chk("fetch_valid", 32'(memory_valid), 1);
    chk("fetch_addr", 32'(memory_addr), 32'(pc));
    memory_ready = 1'b1;
    tick();
    memory_ready = 1'b0;
    tick(lat - 1);
    memory_data_valid = 1'b1;
    memory_data       = ins;
    tick();
    memory_data_valid = 1'b0;
  endtask

  initial begin
    window_chars = {8'h7a, 8'h78, 8'h61, 8'h00};
    tick(2);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", 32'(input_pc_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_valid", 32'(memory_valid), 0);
    chk("rst_mem_addr", 32'(memory_addr), 0);
    chk("rst_out_valid", 32'(output_pc_valid), 0);
    chk("rst_out_pc", {output_cc_id, output_pc}, 0);
    chk("rst_accepts", 32'(accepts), 0);

    // MATCH 'a' with three-cycle memory latency
    hs0 = hs;
    run(8'h10, 2'd1, mk(3'd2, 13'h61), 3);
    chk("m1_valid", 32'(output_pc_valid), 1);
    chk("m1_out", {output_cc_id, output_pc}, {2'd2, 8'h11});
    tick();
    chk("m1_idle", 32'(busy), 0);
    chk("m1_hs", hs - hs0, 1);

    // SPLIT with the consumer stalling four cycles
    hs0 = hs;
    output_pc_ready = 1'b0;
    run(8'h05, 2'd3, mk(3'd1, 13'h40), 1);
    for (int i = 0; i < 4; i++) begin
      chk("split_hold_valid", 32'(output_pc_valid), 1);
      chk("split_hold_out", {output_cc_id, output_pc}, {2'd3, 8'h06});
      if (i == 3) output_pc_ready = 1'b1;
      tick();
    end
    chk("split_second", {output_pc_valid, output_cc_id, output_pc}, {1'b1, 2'd3, 8'h40});
    tick();
    chk("split_idle", 32'(busy), 0);
    chk("split_hs", hs - hs0, 2);

    // MATCH at the last window slot wraps cc_id to 0
    run(8'h20, 2'd3, mk(3'd2, 13'h7a), 2);
    chk("wrap_out", {output_pc_valid, output_cc_id, output_pc}, {1'b1, 2'd0, 8'h21});
    tick();

    // MATCH mismatch drops silently
    run(8'h22, 2'd2, mk(3'd2, 13'h61), 1);
    chk("mismatch_valid", 32'(output_pc_valid), 0);
    tick();
    chk("mismatch_idle", 32'(busy), 0);

    // ACCEPT on end-of-string and on a real character
    acc0 = acc;
    run(8'h30, 2'd0, mk(3'd0, 13'h0), 1);
    chk("acc_pulse", {output_pc_valid, accepts}, 2'b01);
    tick();
    chk("acc_one_pulse", acc - acc0, 1);
    run(8'h31, 2'd2, mk(3'd0, 13'h0), 1);
    chk("acc_x", {output_pc_valid, accepts}, 2'b00);
    tick();
    chk("acc_x_count", acc - acc0, 1);

    // MATCH_ANY on end-of-string, NOT_MATCH, ACCEPT_PARTIAL
    run(8'h32, 2'd0, mk(3'd5, 13'h0), 1);
    chk("any_nul", 32'(output_pc_valid), 0);
    tick();
    run(8'hff, 2'd1, mk(3'd5, 13'h0), 1);
    chk("any_chr", {output_pc_valid, output_cc_id, output_pc}, {1'b1, 2'd2, 8'h00});
    tick();
    run(8'h34, 2'd1, mk(3'd6, 13'h62), 1);
    chk("notm_out", {output_pc_valid, output_cc_id, output_pc}, {1'b1, 2'd2, 8'h35});
    tick();
    run(8'h36, 2'd1, mk(3'd6, 13'h61), 1);
    chk("notm_eq", 32'(output_pc_valid), 0);
    tick();
    run(8'h37, 2'd2, mk(3'd7, 13'h0), 1);
    chk("partial", {output_pc_valid, accepts}, 2'b01);
    tick();

    // JMP finishing while the next thread waits: back-to-back handover
    run(8'h40, 2'd2, mk(3'd3, 13'h33), 1);
    input_pc_valid = 1'b1;
    input_pc       = 8'h50;
    input_cc_id    = 2'd1;
    chk("jmp_out", {output_pc_valid, output_cc_id, output_pc}, {1'b1, 2'd2, 8'h33});
    chk("jmp_in_ready", 32'(input_pc_ready), 1);
    tick();
    input_pc_valid = 1'b0;
    chk("b2b_fetch", {busy, memory_valid, memory_addr}, {1'b1, 1'b1, 11'h050});
    memory_ready = 1'b1;
    tick();
    memory_ready      = 1'b0;
    memory_data_valid = 1'b1;
    memory_data       = mk(3'd4, 13'h0);
    tick();
    memory_data_valid = 1'b0;
    chk("end_drop", {output_pc_valid, accepts}, 2'b00);
    tick();
    chk("end_idle", 32'(busy), 0);

    // reset while waiting on memory, then a stale response
    hs0  = hs;
    acc0 = acc;
    input_pc_valid = 1'b1;
    input_pc       = 8'h60;
    input_cc_id    = 2'd0;
    tick();
    input_pc_valid = 1'b0;
    memory_ready   = 1'b1;
    tick();
    memory_ready = 1'b0;
    reset        = 1'b1;
    tick();
    reset             = 1'b0;
    memory_data_valid = 1'b1;
    memory_data       = mk(3'd7, 13'h0);
    tick();
    memory_data_valid = 1'b0;
    chk("rst_mid_idle", {busy, input_pc_ready}, 2'b01);
    tick(3);
    chk("rst_mid_quiet", {hs - hs0, acc - acc0}, 0);
    chk("rst_mid_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
